shiftreg_feeder: RTL and testbench

Parallel-to-serial loader that sits directly upstream of the bidirectional shift register. It accepts a parallel word plus a shift direction over a valid/ready handshake. It then drives the register's serial `datain` and `mode` inputs for `WIDTH` consecutive clocks, so that the register's `dataout` equals the accepted word. It pulses `done` in exactly the cycle where that holds. The downstream register has no enable and shifts every clock, so `done` is the only qualifier for its parallel output.

---
 rtl/shiftreg_pkg.sv | 21 ++
 rtl/shiftreg_feeder.sv | 124 ++++++++++++
 tb/tb_shiftreg_feeder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// ---------------------------------------------------------------------------
// shiftreg_pkg
// Shared definitions for the bidirectional shift register and its feeder.
//   DEFAULT_WIDTH : default register/word width
//   DIR_LEFT      : direction code for a left shift (mode = 1)
//   DIR_RIGHT     : direction code for a right shift (mode = 0)
//   state_t       : feeder FSM states
// ---------------------------------------------------------------------------
package shiftreg_pkg;

  localparam int   DEFAULT_WIDTH = 4;
  localparam logic DIR_LEFT      = 1'b1;
  localparam logic DIR_RIGHT     = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shiftreg_feeder.sv
// ---------------------------------------------------------------------------
// shiftreg_feeder
// Parallel-to-serial loader placed directly upstream of the bidirectional
// shift register. A word and a direction are accepted over valid/ready, then
// serialised onto datain/mode for WIDTH clocks so that the register's
// parallel output equals the word exactly in the cycle where done is high.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   in_valid  : upstream word available
//   in_ready  : feeder can accept a word this cycle (IDLE or DONE)
//   in_word   : word to load, sampled on accept
//   in_dir    : 1 = left (MSB first), 0 = right (LSB first), sampled on accept
//   datain    : registered serial bit to the shift register
//   mode      : registered direction to the shift register
//   busy      : high while bits are being driven
//   done      : one-cycle pulse, register output valid this cycle
//   exp_word  : copy of the last accepted word
// ---------------------------------------------------------------------------
module shiftreg_feeder
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_dir,
  output logic             datain,
  output logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] exp_word
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             datain_n;
  logic             mode_n;
  logic             busy_n;
  logic             done_n;
  logic [WIDTH-1:0] word_n;
  logic             accept;

  // Bit sent on the idx-th shifting cycle. Left shifts need the MSB to travel
  // furthest, so it goes first; right shifts mirror that with the LSB.
  function automatic logic bit_at(input logic [WIDTH-1:0] w,
                                  input logic [CW-1:0]    idx,
                                  input logic             dir);
    logic r;
    if (dir == DIR_LEFT) r = w[LAST - idx];
    else                 r = w[idx];
    return r;
  endfunction

  assign in_ready = (state == IDLE) || (state == DONE);
  assign accept   = in_valid && in_ready;

  // Next-state and next-output logic. All outputs are registered, so this
  // block computes the value each output takes after the coming edge. The
  // DONE cycle doubles as an accept slot to allow back-to-back words.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    datain_n = 1'b0;
    mode_n   = mode;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    word_n   = exp_word;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_n  = SHIFT;
          cnt_n    = '0;
          datain_n = bit_at(in_word, '0, in_dir);
          mode_n   = in_dir;
          busy_n   = 1'b1;
          word_n   = in_word;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n    = cnt + CW'(1);
          datain_n = bit_at(exp_word, cnt + CW'(1), mode);
          busy_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset wins over any simultaneous accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      datain   <= 1'b0;
      mode     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      exp_word <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      datain   <= datain_n;
      mode     <= mode_n;
      busy     <= busy_n;
      done     <= done_n;
      exp_word <= word_n;
    end
  end

endmodule

// File: tb/tb_shiftreg_feeder.sv
// ---------------------------------------------------------------------------
// tb_shiftreg_feeder
// Drives a 4-bit and an 8-bit feeder, each into a behavioural model of the
// downstream bidirectional shift register. Accepted words push their expected
// serial bits and final register contents into queues; a monitor pops and
// compares whenever busy or done is presented.
// ---------------------------------------------------------------------------
module tb_shiftreg_feeder;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       inValid4 = 1'b0, inDir4 = 1'b0;
  logic [3:0] inWord4 = '0;
  logic       inReady4, datain4, mode4, busy4, done4;
  logic [3:0] expWord4;

  logic       inValid8 = 1'b0, inDir8 = 1'b0;
  logic [7:0] inWord8 = '0;
  logic       inReady8, datain8, mode8, busy8, done8;
  logic [7:0] expWord8;

  logic [3:0] sr4 = '0;
  logic [7:0] sr8 = '0;

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;
  int lastAccept = 0;

  logic [1:0] bitQ4[$];
  logic [1:0] bitQ8[$];
  logic [7:0] expQ4[$];
  logic [7:0] expQ8[$];
  int         doneT4[$];
  int         doneT8[$];

  shiftreg_feeder #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(inValid4), .in_ready(inReady4),
    .in_word(inWord4), .in_dir(inDir4), .datain(datain4), .mode(mode4),
    .busy(busy4), .done(done4), .exp_word(expWord4)
  );

  shiftreg_feeder #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(inValid8), .in_ready(inReady8),
    .in_word(inWord8), .in_dir(inDir8), .datain(datain8), .mode(mode8),
    .busy(busy8), .done(done8), .exp_word(expWord8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural downstream registers: no enable, shift every clock.
  always @(posedge clk) begin
    sr4 <= mode4 ? {sr4[2:0], datain4} : {datain4, sr4[3:1]};
    sr8 <= mode8 ? {sr8[6:0], datain8} : {datain8, sr8[7:1]};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (busy4 === 1'b1) begin
      if (bitQ4.size() == 0) checkOutput("w4 unexpected busy", 1, 0);
      else checkOutput("w4 datain/mode", {datain4, mode4}, bitQ4.pop_front());
    end
    if (done4 === 1'b1) begin
      doneT4.push_back(cycle);
      if (expQ4.size() == 0) checkOutput("w4 unexpected done", 1, 0);
      else begin
        logic [7:0] e;
        e = expQ4.pop_front();
        checkOutput("w4 dataout", sr4, e);
        checkOutput("w4 exp_word", expWord4, e);
      end
    end
    if (busy8 === 1'b1) begin
      if (bitQ8.size() == 0) checkOutput("w8 unexpected busy", 1, 0);
      else checkOutput("w8 datain/mode", {datain8, mode8}, bitQ8.pop_front());
    end
    if (done8 === 1'b1) begin
      doneT8.push_back(cycle);
      if (expQ8.size() == 0) checkOutput("w8 unexpected done", 1, 0);
      else begin
        logic [7:0] e;
        e = expQ8.pop_front();
        checkOutput("w8 dataout", sr8, e);
        checkOutput("w8 exp_word", expWord8, e);
      end
    end
  end

  // Offer a word and wait for it to be accepted; on accept, queue the
  // expected serial bits and final word. Returns 1 time unit after E0.
  task automatic applyStimulus(input bit big, input logic [7:0] word,
                               input logic dir, input bit keepValid);
    int  n;
    bit  ok;
    n  = big ? 8 : 4;
    ok = 1'b0;
    if (big) begin inValid8 = 1'b1; inWord8 = word; inDir8 = dir; end
    else begin inValid4 = 1'b1; inWord4 = word[3:0]; inDir4 = dir; end
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if ((big ? inReady8 : inReady4) === 1'b1) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    if (!ok) begin
      checkOutput("accept timeout", 0, 1);
    end else begin
      lastAccept = cycle;
      for (int i = 0; i < n; i++) begin
        logic b;
        b = dir ? word[n-1-i] : word[i];
        if (big) bitQ8.push_back({b, dir});
        else     bitQ4.push_back({b, dir});
      end
      if (big) expQ8.push_back(word);
      else     expQ4.push_back(word);
    end
    if (!keepValid) begin
      if (big) inValid8 = 1'b0;
      else     inValid4 = 1'b0;
    end
  endtask

  task automatic waitIdle(input bit big);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (big) ok = (expQ8.size() == 0) && (busy8 === 1'b0) && (done8 === 1'b0);
      else     ok = (expQ4.size() == 0) && (busy4 === 1'b0) && (done4 === 1'b0);
    end
    if (!ok) checkOutput("idle timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lowCnt;
    $display("[TB] start");

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset datain", datain4, 0);
    checkOutput("reset mode", mode4, 0);
    checkOutput("reset busy", busy4, 0);
    checkOutput("reset done", done4, 0);
    checkOutput("reset exp_word", expWord4, 0);
    checkOutput("reset in_ready", inReady4, 1);
    checkOutput("reset in_ready w8", inReady8, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Left then right shift of 1011
    applyStimulus(1'b0, 8'h0B, 1'b1, 1'b0);
    waitIdle(1'b0);
    applyStimulus(1'b0, 8'h0B, 1'b0, 1'b0);
    waitIdle(1'b0);

    // Back-to-back with in_valid held: second word taken in DONE cycle
    doneT4.delete();
    applyStimulus(1'b0, 8'h0C, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h03, 1'b0, 1'b0);
    waitIdle(1'b0);
    checkOutput("b2b done count", doneT4.size(), 2);
    if (doneT4.size() == 2)
      checkOutput("b2b done spacing", doneT4[1] - doneT4[0], 5);

    // Upstream changes during SHIFT must be ignored
    applyStimulus(1'b0, 8'h09, 1'b0, 1'b0);
    inValid4 = 1'b1; inWord4 = 4'b0110; inDir4 = 1'b1;
    @(negedge clk);
    checkOutput("in_ready in shift a", inReady4, 0);
    @(posedge clk);
    #1 inValid4 = 1'b0; inWord4 = 4'b1111;
    @(negedge clk);
    checkOutput("in_ready in shift b", inReady4, 0);
    @(posedge clk);
    #1 inWord4 = 4'b0000; inDir4 = 1'b0;
    waitIdle(1'b0);

    // Reset after two bits of a left word: abort with no done
    applyStimulus(1'b0, 8'h06, 1'b1, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    bitQ4.delete();
    expQ4.delete();
    checkOutput("abort datain", datain4, 0);
    checkOutput("abort mode", mode4, 0);
    checkOutput("abort busy", busy4, 0);
    checkOutput("abort in_ready", inReady4, 1);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Width 8, A5 left: done 8 cycles after accept, in_ready low 8 cycles
    doneT8.delete();
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    lowCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inReady8 === 1'b0) lowCnt++;
      else break;
    end
    checkOutput("w8 in_ready low cycles", lowCnt, 8);
    waitIdle(1'b1);
    checkOutput("w8 done count", doneT8.size(), 1);
    if (doneT8.size() == 1)
      checkOutput("w8 latency", doneT8[0] - lastAccept, 8);

    checkOutput("queues drained",
                bitQ4.size() + bitQ8.size() + expQ4.size() + expQ8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
